// File: rtl/a2d_serf.sv
// -----------------------------------------------------------------------------
// a2d_serf
//
// SPI responder that stands in for the 8-channel, 12-bit A2D converter at the
// far end of the A2D interface / SPI monarch link. Each frame carries a 16-bit
// command whose bits [13:11] select a channel. At the same time the frame
// shifts out {4'h0, smpl}. smpl is the sample the environment presents for the
// channel latched by the previous frame, so responses lag commands by one
// frame, as on the real converter.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   SS_n      active-low select from the monarch (asynchronous to clk)
//   SCLK      SPI clock from the monarch, idles high (asynchronous to clk)
//   MOSI      command bit stream, MSB first (asynchronous to clk)
//   MISO      response bit stream, MSB first; 0 outside a frame
//   smpl      12-bit sample for the channel currently on chnnl
//   chnnl     channel latched by the last good (16-bit) command frame
//   frm_done  one-cycle pulse: a 16-bit frame completed and chnnl was updated
//   frm_err   one-cycle pulse: a frame ended with a bit count other than 16
// -----------------------------------------------------------------------------
module a2d_serf #(
    parameter int SYNC_STAGES = 2   // metastability flops per pin, 2..3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [11:0] smpl,
    output logic [2:0]  chnnl,
    output logic        frm_done,
    output logic        frm_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [4:0] CNT_FRAME = 5'd16;  // bits in a good frame
    localparam logic [4:0] CNT_SAT   = 5'd17;  // any count past a full frame

    // -------------------------------------------------------------------------
    // Pin synchronizers plus one extra stage on SS_n/SCLK for edge detection.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   ss_prev;
    logic                   sclk_prev;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    // SS_n/SCLK stages reset to their idle level (1) so that releasing reset
    // with the bus idle cannot fabricate an ss_fall or sclk_rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= '1;
            sclk_sync <= '1;
            mosi_sync <= '0;
            ss_prev   <= 1'b1;
            sclk_prev <= 1'b1;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0],   SS_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            ss_prev   <= ss_sync[SYNC_STAGES-1];
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
        end
    end

    logic ss_fall;
    logic ss_rise;
    logic sclk_rise;
    logic mosi_bit;

    // SCLK falls are not needed: data is both captured and advanced on the
    // detected rise, and the synchronizer latency keeps the old MISO bit on
    // the pin through the monarch's own sampling edge.
    assign ss_fall   =  ss_prev   & ~ss_sync[SYNC_STAGES-1];
    assign ss_rise   = ~ss_prev   &  ss_sync[SYNC_STAGES-1];
    assign sclk_rise = ~sclk_prev &  sclk_sync[SYNC_STAGES-1];
    assign mosi_bit  =  mosi_sync[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Frame FSM and datapath
    // -------------------------------------------------------------------------
    state_t      state;
    state_t      state_nxt;
    logic [15:0] shft_reg;
    logic [15:0] shft_nxt;
    logic [4:0]  bit_cnt;
    logic [4:0]  cnt_nxt;
    logic [2:0]  chnnl_nxt;
    logic        done_nxt;
    logic        err_nxt;

    // Shift/count as they would be after this cycle's sclk_rise. These are
    // also used for the end-of-frame check, so a final SCLK rise that lands
    // in the same cycle as ss_rise still counts toward the frame.
    logic [15:0] shft_upd;
    logic [4:0]  cnt_upd;

    always_comb begin
        shft_upd = shft_reg;
        cnt_upd  = bit_cnt;
        if (sclk_rise) begin
            shft_upd = {shft_reg[14:0], mosi_bit};
            if (bit_cnt != CNT_SAT) begin
                cnt_upd = bit_cnt + 5'd1;
            end
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        shft_nxt  = shft_reg;
        cnt_nxt   = bit_cnt;
        chnnl_nxt = chnnl;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;

        case (state)
            IDLE: begin
                // SCLK activity while deselected is ignored.
                if (ss_fall) begin
                    shft_nxt  = {4'h0, smpl};
                    cnt_nxt   = 5'd0;
                    state_nxt = SHIFT;
                end
            end

            SHIFT: begin
                shft_nxt = shft_upd;
                cnt_nxt  = cnt_upd;
                if (ss_rise) begin
                    state_nxt = IDLE;
                    if (cnt_upd == CNT_FRAME) begin
                        // Command is {2'bxx, chnnl[2:0], 11'hxxx}; only the
                        // channel field matters.
                        chnnl_nxt = shft_upd[13:11];
                        done_nxt  = 1'b1;
                    end else begin
                        err_nxt   = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shft_reg <= 16'h0000;
            bit_cnt  <= 5'd0;
            chnnl    <= 3'h0;
            frm_done <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            shft_reg <= shft_nxt;
            bit_cnt  <= cnt_nxt;
            chnnl    <= chnnl_nxt;
            frm_done <= done_nxt;
            frm_err  <= err_nxt;
        end
    end

    // MISO is driven only inside a frame.
    assign MISO = (state == SHIFT) ? shft_reg[15] : 1'b0;

endmodule

// File: doc/a2d_serf.md
# a2d_serf

SPI serf (responder) that emulates the 8-channel, 12-bit A2D converter sitting on the far end of the team's A2D interface/SPI monarch link. It receives the 16-bit channel command frame, latches the requested channel, and on every frame shifts out the 12-bit sample of the channel latched by the previous frame, pipelined like the real converter. Used as the converter stand-in in top-level simulation and as an on-FPGA loopback target on the DE0-Nano.

## Interface
- Parameters
- SYNC_STAGES, 2: metastability flops on SS_n, SCLK and MOSI before edge detection; legal range 2–3.
- Ports
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- SS_n  input  1  active-low serf select from monarch
- SCLK  input  1  SPI clock from monarch; idles high
- MOSI  input  1  command data from monarch, MSB first
- MISO  output  1  response data to monarch, MSB first
- smpl  input  12  sample value for the channel currently on `chnnl`; supplied by testbench or on-board source
- chnnl  output  3  channel latched from the last good command frame
- frm_done  output  1  one-cycle pulse: 16-bit frame completed, `chnnl` updated
- frm_err  output  1  one-cycle pulse: frame ended with bit count ≠ 16; `chnnl` unchanged

## Operation
- Synchronizer: SS_n, SCLK, MOSI each pass through SYNC_STAGES flops, plus one more flop for SS_n and SCLK to form edge detects. SS_n/SCLK sync flops reset to 1, MOSI to 0.
- Edge events, all one-cycle: ss_fall, ss_rise, sclk_rise. SCLK falls are ignored.
- FSM, 2 states:
- IDLE: waits for ss_fall. On ss_fall: shft_reg ← {4'h0, smpl}, bit_cnt ← 0, go to SHIFT.
- SHIFT: on each sclk_rise, shft_reg ← {shft_reg[14:0], MOSI_sync}; bit_cnt increments, saturating at 17. On ss_rise go to IDLE. If bit_cnt == 16, chnnl ← shft_reg[13:11] and pulse frm_done; otherwise pulse frm_err.
- MISO = shft_reg[15] while in SHIFT, otherwise 0.
- Command format: {2'b00, chnnl[2:0], 11'h000}. Bits [15:14] and [10:0] are ignored and do not cause an error.
- Response format: {4'h0, smpl[11:0]}. smpl is captured once, at ss_fall, and held for the rest of the frame.
- Pipelining: the frame carrying command N returns the sample of the channel latched by frame N-1. The first frame after reset returns channel 0.
- sclk_rise while in IDLE: ignored.
- ss_fall while in SHIFT cannot occur, because ss_rise must come first.
- Reset mid-frame: FSM goes to IDLE, shft_reg = 0, bit_cnt = 0, chnnl = 0, and no pulses are produced. The next ss_fall starts a fresh frame.
- If ss_rise and sclk_rise occur in the same cycle, the shift is applied first and the count check uses the updated count.

## Timing
- Reset values: MISO 0, chnnl 3'h0, frm_done 0, frm_err 0, state IDLE.
- Event latency: an event is detected SYNC_STAGES+1 clk after the pin edge (3 clk at the default).
- shft_reg is loaded on the detection cycle of ss_fall. MISO bit 15 is valid one clk later.
- After each sclk_rise, MISO advances to the next bit SYNC_STAGES+2 clk after the pin edge. The monarch samples MISO on its own SCLK rise, so the old bit is held through that sample.
- Monarch constraints: at least 4 clk from SS_n fall to the first SCLK fall; SCLK high and low phases at least 4 clk each; MOSI stable around SCLK rise; at least 4 clk of SS_n high between frames.
- chnnl updates, and frm_done/frm_err pulse, in the ss_rise detection cycle.

## Test plan
- Reset, then a frame with command 16'h1800 (channel 3) and smpl = 12'hABC: MISO returns 16'h0ABC; chnnl = 3 and frm_done pulses once.
- Second frame, command 16'h1800, smpl = 12'h5A5: response 16'h05A5; chnnl stays 3.
- Back-to-back frames with commands ch 7 then ch 2, driven by the monarch at SCLK = clk/32: the second response carries the sample presented at its ss_fall; chnnl ends at 2.
- Frame aborted after 9 SCLK rises: frm_err pulses and chnnl is unchanged. The next 16-bit frame completes normally.
- rst_n asserted mid-frame after bit 6: MISO = 0 and chnnl = 0 immediately, with no pulses. The following full frame succeeds.
- Command 16'hFFFF: only bits [13:11] are used, so chnnl = 7 and no error is flagged; 20 SCLK rises gives frm_err.
